// File: rtl/rr_slave_arbiter.sv
// Round-robin arbiter sharing one slave request/response port between
// MASTER_COUNT masters. One outstanding transaction at a time. A response
// timeout returns an error to a master whose slave has stalled.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; picks the next winner, drains stray responses
// REQ   | granted master's request presented to the slave
// RSP   | waiting for / forwarding the slave response, timer running
// TERR  | timeout error response presented to the granted master
module rr_slave_arbiter #(
  parameter int MASTER_COUNT   = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int MID_W         = $clog2(MASTER_COUNT)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [MASTER_COUNT-1:0]                m_req_valid_i,
  output logic [MASTER_COUNT-1:0]                m_req_ready_o,
  input  logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0] m_req_addr_i,
  input  logic [MASTER_COUNT-1:0]                m_req_we_i,
  input  logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0] m_req_wdata_i,
  output logic [MASTER_COUNT-1:0]                m_rsp_valid_o,
  input  logic [MASTER_COUNT-1:0]                m_rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                  m_rsp_rdata_o,
  output logic                                   m_rsp_err_o,
  output logic                                   s_req_valid_o,
  input  logic                                   s_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                  s_req_addr_o,
  output logic                                   s_req_we_o,
  output logic [DATA_WIDTH-1:0]                  s_req_wdata_o,
  input  logic                                   s_rsp_valid_i,
  output logic                                   s_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]                  s_rsp_rdata_i,
  input  logic                                   s_rsp_err_i,
  output logic [MID_W-1:0]                       grant_id_o,
  output logic                                   busy_o,
  output logic                                   timeout_o,
  output logic                                   stray_rsp_o
);

  // A zero timeout disables the timer; keep it one bit wide in that case.
  localparam int              TMR_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam bit              TMR_EN    = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_TERR = 2'd3;

  logic [1:0]       state_q;
  logic [MID_W-1:0] grant_q;
  logic [MID_W-1:0] last_q;
  logic [TMR_W-1:0] timer_q;

  logic             win_found;
  logic [MID_W-1:0] win_id;
  logic [MID_W-1:0] scan_id;
  logic             tmo_hit;

  // Round-robin search: first valid master after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int i = 1; i <= MASTER_COUNT; i++) begin
      scan_id = MID_W'((int'(last_q) + i) % MASTER_COUNT);
      if (!win_found && m_req_valid_i[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // Timeout only fires while the slave is silent; a held response is never aborted.
  assign tmo_hit = TMR_EN && (state_q == ST_RSP) && !s_rsp_valid_i && (timer_q == TMR_LIMIT);

  // Transaction sequencing, grant bookkeeping and the saturating response timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= MID_W'(MASTER_COUNT - 1);
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q <= win_id;
            last_q  <= win_id;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_ready_i) begin
            state_q <= ST_RSP;
            timer_q <= '0;
          end
        end
        ST_RSP: begin
          if (s_rsp_valid_i && m_rsp_ready_i[grant_q]) begin
            state_q <= ST_IDLE;
          end else if (tmo_hit) begin
            state_q <= ST_TERR;
          end else if (!s_rsp_valid_i && (timer_q != '1)) begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        ST_TERR: begin
          if (m_rsp_ready_i[grant_q]) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-state steering between the granted master and the slave port.
  always_comb begin
    m_req_ready_o = '0;
    m_rsp_valid_o = '0;
    m_rsp_rdata_o = '0;
    m_rsp_err_o   = 1'b0;
    s_req_valid_o = 1'b0;
    s_req_addr_o  = '0;
    s_req_we_o    = 1'b0;
    s_req_wdata_o = '0;
    s_rsp_ready_o = 1'b0;
    stray_rsp_o   = 1'b0;
    timeout_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_rsp_ready_o = 1'b1;
        stray_rsp_o   = s_rsp_valid_i;
      end
      ST_REQ: begin
        s_req_valid_o          = 1'b1;
        s_req_addr_o           = m_req_addr_i[grant_q];
        s_req_we_o             = m_req_we_i[grant_q];
        s_req_wdata_o          = m_req_wdata_i[grant_q];
        m_req_ready_o[grant_q] = s_req_ready_i;
      end
      ST_RSP: begin
        m_rsp_valid_o[grant_q] = s_rsp_valid_i;
        m_rsp_rdata_o          = s_rsp_rdata_i;
        m_rsp_err_o            = s_rsp_err_i;
        s_rsp_ready_o          = m_rsp_ready_i[grant_q];
        timeout_o              = tmo_hit;
      end
      ST_TERR: begin
        m_rsp_valid_o[grant_q] = 1'b1;
        m_rsp_err_o            = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule
